// File: rtl/uart_host_master.sv
// uart_host_master
// Host-side UART command initiator. Turns a parallel register request into
// 8N1 frames on uart_txd: command byte {write, addr[6:0]}, then the data byte
// for writes. For reads it waits on uart_rxd for a single response byte and
// gives up after TIMEOUT_BITS bit periods.
//
// Ports:
//   clk, n_reset            system clock, asynchronous active-low reset
//   uart_txd                serial out (idles high, registered)
//   uart_rxd                serial in (asynchronous, synchronized here)
//   req_valid/req_ready     request handshake; fields captured on accept
//   req_write, req_addr,
//   req_wdata               request fields
//   rsp_valid               one-cycle completion pulse (the DONE state)
//   rsp_rdata               last good read byte, held between responses
//   rsp_err                 read timeout or framing error, qualifies rsp_valid
//   busy                    inverse of req_ready
module uart_host_master #(
    parameter int UART_CLK_FREQ = 24_000_000,
    parameter int UART_BAUD     = 115_200,
    parameter int TIMEOUT_BITS  = 64
) (
    input  logic       clk,
    input  logic       n_reset,
    output logic       uart_txd,
    input  logic       uart_rxd,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       busy
);

    localparam int DIV    = UART_CLK_FREQ / UART_BAUD;
    localparam int HALF   = DIV / 2;
    localparam int TO_CYC = TIMEOUT_BITS * DIV;
    localparam int BW     = $clog2(DIV + 1);
    localparam int TW     = $clog2(TO_CYC + 1);

    localparam logic [BW-1:0] DIV_M1  = BW'(DIV - 1);
    localparam logic [BW-1:0] DIV_END = BW'(DIV);
    localparam logic [BW-1:0] HALF_M1 = BW'(HALF - 1);
    localparam logic [TW-1:0] TO_M1   = TW'(TO_CYC - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] TX_CMD  = 3'd1;
    localparam logic [2:0] TX_DATA = 3'd2;
    localparam logic [2:0] RX_WAIT = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    localparam logic [1:0] RX_HUNT  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;

    logic [2:0]    state;
    logic          wr_q;
    logic [7:0]    wdata_q;
    logic          txd_q;
    logic [8:0]    tx_shift;    // remaining bits of the frame: {stop, data}
    logic [3:0]    tx_bit;      // 0 = start, 1..8 = data, 9 = stop
    logic [BW-1:0] tx_cnt;
    logic [BW-1:0] tx_limit;

    logic          rx_s1, rx_s2, rx_prev;
    logic [1:0]    rx_phase;
    logic [BW-1:0] rx_cnt;
    logic [3:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic [TW-1:0] to_cnt;

    logic [7:0]    rdata_q;
    logic          err_q;

    // The data frame's stop bit is stretched by one cycle before DONE. The
    // line already idles high afterwards, so this is invisible on the wire,
    // and it places rsp_valid at 20*DIV+1 cycles after the accept edge.
    assign tx_limit = (state == TX_DATA && tx_bit == 4'd9) ? DIV_END : DIV_M1;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state    <= IDLE;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            txd_q    <= 1'b1;
            tx_shift <= '0;
            tx_bit   <= '0;
            tx_cnt   <= '0;
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_phase <= RX_HUNT;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            to_cnt   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rx_s1   <= uart_rxd;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state    <= TX_CMD;
                        wr_q     <= req_write;
                        wdata_q  <= req_wdata;
                        txd_q    <= 1'b0;
                        tx_shift <= {1'b1, req_write, req_addr};
                        tx_bit   <= '0;
                        tx_cnt   <= '0;
                    end
                end

                TX_CMD, TX_DATA: begin
                    if (tx_cnt == tx_limit) begin
                        tx_cnt <= '0;
                        if (tx_bit == 4'd9) begin
                            tx_bit <= '0;
                            if (state == TX_DATA) begin
                                state <= DONE;
                                err_q <= 1'b0;
                            end else if (wr_q) begin
                                // data start bit follows the stop bit directly
                                state    <= TX_DATA;
                                txd_q    <= 1'b0;
                                tx_shift <= {1'b1, wdata_q};
                            end else begin
                                state    <= RX_WAIT;
                                to_cnt   <= '0;
                                rx_phase <= RX_HUNT;
                            end
                        end else begin
                            tx_bit   <= tx_bit + 4'd1;
                            txd_q    <= tx_shift[0];
                            tx_shift <= {1'b1, tx_shift[8:1]};
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end

                RX_WAIT: begin
                    // timeout runs until a start bit is confirmed
                    if (rx_phase != RX_DATA) begin
                        if (to_cnt == TO_M1) begin
                            state <= DONE;
                            err_q <= 1'b1;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end

                    case (rx_phase)
                        RX_HUNT: begin
                            if (rx_prev && !rx_s2) begin
                                rx_phase <= RX_START;
                                rx_cnt   <= '0;
                            end
                        end
                        RX_START: begin
                            if (rx_cnt == HALF_M1) begin
                                rx_cnt <= '0;
                                if (!rx_s2) begin
                                    rx_phase <= RX_DATA;
                                    rx_bit   <= '0;
                                end else begin
                                    rx_phase <= RX_HUNT;  // false start
                                end
                            end else begin
                                rx_cnt <= rx_cnt + 1'b1;
                            end
                        end
                        RX_DATA: begin
                            if (rx_cnt == DIV_M1) begin
                                rx_cnt <= '0;
                                if (rx_bit == 4'd8) begin
                                    state    <= DONE;
                                    rx_phase <= RX_HUNT;
                                    if (rx_s2) begin
                                        rdata_q <= rx_shift;
                                        err_q   <= 1'b0;
                                    end else begin
                                        err_q   <= 1'b1;
                                    end
                                end else begin
                                    rx_shift <= {rx_s2, rx_shift[7:1]};
                                    rx_bit   <= rx_bit + 4'd1;
                                end
                            end else begin
                                rx_cnt <= rx_cnt + 1'b1;
                            end
                        end
                        default: rx_phase <= RX_HUNT;
                    endcase
                end

                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign uart_txd  = txd_q;
    assign req_ready = (state == IDLE);
    assign busy      = ~req_ready;
    assign rsp_valid = (state == DONE);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_uart_host_master.sv
// Bench for uart_host_master at DIV = 16. Requests come from a vector table;
// expected responses go to a scoreboard queue when a request is accepted and
// are checked by a monitor when rsp_valid pulses. A chip model drives uart_rxd
// for reads. Extra sequences cover back-to-back writes and mid-frame reset.
module tb_uart_host_master;

    localparam int DIV = 16;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       uart_txd;
    logic       uart_rxd = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_write = 1'b0;
    logic [6:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       busy;

    uart_host_master #(
        .UART_CLK_FREQ(1_600_000),
        .UART_BAUD    (100_000),
        .TIMEOUT_BITS (64)
    ) dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .uart_txd (uart_txd),
        .uart_rxd (uart_rxd),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // mode: 0 no reply, 1 good reply, 2 bad stop, 3 glitch then bad stop
    typedef struct {
        logic       wr;
        logic [6:0] addr;
        logic [7:0] wdata;
        int         mode;
        logic [7:0] reply;
        logic       exp_err;
        logic [7:0] exp_rdata;
        int         exp_lat;
    } vec_t;

    typedef struct {
        logic       err;
        logic [7:0] rdata;
        int         acc;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    logic prev_rv = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard consumer
    always @(negedge clk) begin
        if (rsp_valid) begin
            chk("rsp_single_pulse", int'(prev_rv), 0);
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_err", int'(rsp_err), int'(e.err));
                chk("rsp_rdata", int'(rsp_rdata), int'(e.rdata));
                if (e.lat > 0) chk("rsp_latency", cyc - e.acc, e.lat);
            end
        end
        prev_rv = rsp_valid;
    end

    // Sample the 10 bits of a frame at bit midpoints; the frame's start bit
    // begins on edge a+off.
    task automatic check_frame(input string name, input int a, input int off,
                               input logic [7:0] exp);
        logic [9:0] f;
        logic [9:0] want;
        want = {1'b1, exp, 1'b0};
        for (int i = 0; i < 10; i++) begin
            while (cyc < a + off + DIV * i + DIV / 2) @(negedge clk);
            f[i] = uart_txd;
        end
        chk(name, int'(f), int'(want));
    endtask

    // Chip reply: optional 4-cycle glitch, then a frame 20 bit-times after
    // the command stop bit ends (edge a+160).
    task automatic drive_reply(input int a, input vec_t v);
        logic [9:0] bits;
        if (v.mode == 3) begin
            while (cyc < a + 300) @(negedge clk);
            uart_rxd = 1'b0;
            repeat (4) @(negedge clk);
            uart_rxd = 1'b1;
        end
        bits = {(v.mode == 1) ? 1'b1 : 1'b0, v.reply, 1'b0};
        while (cyc < a + 10 * DIV + 20 * DIV) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            uart_rxd = bits[i];
            repeat (DIV) @(negedge clk);
        end
        uart_rxd = 1'b1;
    endtask

    task automatic do_req(input vec_t v, output int a);
        int t;
        @(negedge clk);
        req_write = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_valid = 1'b1;
        t = 0;
        while (!req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) chk("accept_timeout", 0, 1);
        a = cyc + 1;
        sb.push_back('{err: v.exp_err, rdata: v.exp_rdata, acc: a, lat: v.exp_lat});
        @(negedge clk);
        req_valid = 1'b0;
        req_write = ~v.wr;   // fields must have been captured at accept
        req_addr  = ~v.addr;
        req_wdata = ~v.wdata;
    endtask

    task automatic wait_done();
        int t = 0;
        while (sb.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            chk("rsp_missing", sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        int a;
        do_req(v, a);
        check_frame("txd_cmd_frame", a, 0, {v.wr, v.addr});
        if (v.wr) check_frame("txd_data_frame", a, 10 * DIV, v.wdata);
        else if (v.mode != 0) drive_reply(a, v);
        wait_done();
    endtask

    vec_t vecs[6];

    initial begin
        // write 321 = 20*DIV+1; read reply 635 = 480 + 2 sync + 1 edge + 8 + 9*16;
        // timeout 1184 = 160 + 64*16
        vecs[0] = '{1'b1, 7'h05, 8'hA3, 0, 8'h00, 1'b0, 8'h00, 321};
        vecs[1] = '{1'b0, 7'h10, 8'h00, 1, 8'h5C, 1'b0, 8'h5C, 635};
        vecs[2] = '{1'b0, 7'h22, 8'h00, 0, 8'h00, 1'b1, 8'h5C, 1184};
        vecs[3] = '{1'b0, 7'h33, 8'h00, 3, 8'h77, 1'b1, 8'h5C, 635};
        vecs[4] = '{1'b0, 7'h44, 8'h00, 1, 8'h3A, 1'b0, 8'h3A, 635};
        vecs[5] = '{1'b1, 7'h7F, 8'h00, 0, 8'h00, 1'b0, 8'h3A, 321};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_txd", int'(uart_txd), 1);
        chk("rst_ready", int'(req_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rdata", int'(rsp_rdata), 0);
        chk("rst_err", int'(rsp_err), 0);
        n_reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // back-to-back writes with req_valid held high
        begin
            logic [6:0] ba[3];
            logic [7:0] bd[3];
            int a, pa, t;
            ba = '{7'h01, 7'h02, 7'h03};
            bd = '{8'h11, 8'h22, 8'h33};
            pa = 0;
            @(negedge clk);
            req_write = 1'b1;
            req_addr  = ba[0];
            req_wdata = bd[0];
            req_valid = 1'b1;
            for (int k = 0; k < 3; k++) begin
                t = 0;
                while (!req_ready && t < 400) begin
                    @(negedge clk);
                    t++;
                end
                if (!req_ready) chk("b2b_accept_timeout", 0, 1);
                a = cyc + 1;
                if (k > 0) chk("b2b_accept_spacing", a - pa, 20 * DIV + 3);
                pa = a;
                sb.push_back('{err: 1'b0, rdata: 8'h3A, acc: a, lat: 321});
                @(negedge clk);
                chk("b2b_ready_one_cycle", int'(req_ready), 0);
                if (k < 2) begin
                    req_addr  = ba[k+1];
                    req_wdata = bd[k+1];
                end
                check_frame("b2b_cmd_frame", a, 0, {1'b1, ba[k]});
                check_frame("b2b_data_frame", a, 10 * DIV, bd[k]);
                if (k == 2) req_valid = 1'b0;
            end
            wait_done();
        end

        // reset in the middle of a write's data frame
        begin
            vec_t v;
            int a;
            v = '{1'b1, 7'h0A, 8'h55, 0, 8'h00, 1'b0, 8'h3A, 321};
            do_req(v, a);
            while (cyc < a + 200) @(negedge clk);
            #2 n_reset = 1'b0;
            #1;
            chk("midrst_txd", int'(uart_txd), 1);
            chk("midrst_ready", int'(req_ready), 1);
            chk("midrst_busy", int'(busy), 0);
            chk("midrst_rsp_valid", int'(rsp_valid), 0);
            chk("midrst_rdata", int'(rsp_rdata), 0);
            sb.delete();
            repeat (3) @(negedge clk);
            n_reset = 1'b1;
            repeat (2) @(negedge clk);
            chk("postrst_txd_idle", int'(uart_txd), 1);
            run_vec('{1'b0, 7'h10, 8'h00, 1, 8'hA5, 1'b0, 8'hA5, 635});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
